// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer: FSM states,
// opcode classes, ALU function codes and operand-B select codes.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_OP,
    CL_OPIMM,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] OPB_RSB = 2'd0;
  localparam logic [1:0] OPB_PC  = 2'd1;
  localparam logic [1:0] OPB_IMI = 2'd2;
  localparam logic [1:0] OPB_IMS = 2'd3;

  function automatic op_class_t classify(input logic [6:0] opcode);
    case (opcode)
      OPC_OP:     classify = CL_OP;
      OPC_OPIMM:  classify = CL_OPIMM;
      OPC_LOAD:   classify = CL_LOAD;
      OPC_STORE:  classify = CL_STORE;
      OPC_BRANCH: classify = CL_BRANCH;
      default:    classify = CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_fun_decode.sv
// Maps opcode class, funct3 and funct7[5] to the ALU function code.
module alu_fun_decode
  import core_ctrl_pkg::*;
(
  input  op_class_t   op_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_b5,
  output logic [3:0]  alu_fun
);

  always_comb begin
    alu_fun = ALU_ADD;
    case (op_class)
      CL_OP, CL_OPIMM: begin
        case (funct3)
          // OP-IMM has no SUBI: bit 30 there is immediate data
          3'b000: alu_fun = (op_class == CL_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_fun = ALU_SLL;
          3'b010: alu_fun = ALU_SLT;
          3'b011: alu_fun = ALU_SLTU;
          3'b100: alu_fun = ALU_XOR;
          3'b101: alu_fun = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_fun = ALU_OR;
          default: alu_fun = ALU_AND;
        endcase
      end
      CL_BRANCH: alu_fun = ALU_SUB;
      default:   alu_fun = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Outputs are decoded combinationally from the state and the latched instruction.
module multicycle_ctrl
  import core_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] io_inst,
  output logic        io_imem_req,
  input  logic        io_imem_ack,
  output logic        io_dmem_req,
  output logic        io_dmem_we,
  input  logic        io_dmem_ack,
  input  logic        io_br_taken,
  output logic        io_ir_we,
  output logic [1:0]  io_opb_sel,
  output logic [3:0]  io_alu_fun,
  output logic        io_rf_we,
  output logic        io_wb_sel,
  output logic        io_pc_we,
  output logic        io_pc_sel,
  output logic        io_illegal
);

  state_t    state;
  op_class_t op_class;
  logic [3:0] dec_fun;
  logic [1:0] dec_opb;
  logic       unused_inst_bits;

  assign op_class = classify(io_inst[6:0]);
  assign unused_inst_bits = ^{io_inst[31], io_inst[29:15], io_inst[11:7]};

  alu_fun_decode u_alu_fun_decode (
    .op_class (op_class),
    .funct3   (io_inst[14:12]),
    .funct7_b5(io_inst[30]),
    .alu_fun  (dec_fun)
  );

  always_comb begin
    case (op_class)
      CL_STORE:           dec_opb = OPB_IMS;
      CL_OPIMM, CL_LOAD:  dec_opb = OPB_IMI;
      default:            dec_opb = OPB_RSB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH:  if (io_imem_ack) state <= ST_DECODE;
        ST_DECODE: state <= (op_class == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
        ST_EXEC: begin
          case (op_class)
            CL_BRANCH:         state <= ST_FETCH;
            CL_LOAD, CL_STORE: state <= ST_MEM;
            default:           state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (io_dmem_ack) state <= (op_class == CL_STORE) ? ST_FETCH : ST_WB;
        end
        ST_WB:   state <= ST_FETCH;
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Everything is forced low while reset is sampled, abandoning any open request.
  always_comb begin
    io_imem_req = 1'b0;
    io_dmem_req = 1'b0;
    io_dmem_we  = 1'b0;
    io_ir_we    = 1'b0;
    io_opb_sel  = OPB_RSB;
    io_alu_fun  = ALU_ADD;
    io_rf_we    = 1'b0;
    io_wb_sel   = 1'b0;
    io_pc_we    = 1'b0;
    io_pc_sel   = 1'b0;
    io_illegal  = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          io_imem_req = 1'b1;
          io_ir_we    = io_imem_ack;
        end
        ST_EXEC: begin
          io_opb_sel = dec_opb;
          io_alu_fun = dec_fun;
          if (op_class == CL_BRANCH) begin
            io_pc_we  = 1'b1;
            io_pc_sel = io_br_taken;
          end
        end
        ST_MEM: begin
          io_opb_sel  = dec_opb;
          io_alu_fun  = dec_fun;
          io_dmem_req = 1'b1;
          io_dmem_we  = (op_class == CL_STORE);
          io_pc_we    = (op_class == CL_STORE) && io_dmem_ack;
        end
        ST_WB: begin
          io_rf_we  = 1'b1;
          io_wb_sel = (op_class == CL_LOAD);
          io_pc_we  = 1'b1;
        end
        ST_TRAP: io_illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector tables for the
// documented scenarios plus random instructions checked against a trace model.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic [1:0] opb;
    logic [3:0] fun;
    logic       rf_we;
    logic       wb_sel;
    logic       pc_we;
    logic       pc_sel;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic  rst;
    logic  imem_ack;
    logic  dmem_ack;
    logic  br;
    outs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] io_inst;
  logic        io_imem_req, io_imem_ack, io_dmem_req, io_dmem_we, io_dmem_ack;
  logic        io_br_taken, io_ir_we, io_rf_we, io_wb_sel, io_pc_we, io_pc_sel, io_illegal;
  logic [1:0]  io_opb_sel;
  logic [3:0]  io_alu_fun;
  outs_t       act;

  int checks = 0;
  int errors = 0;
  vec_t q[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .io_inst(io_inst),
    .io_imem_req(io_imem_req), .io_imem_ack(io_imem_ack),
    .io_dmem_req(io_dmem_req), .io_dmem_we(io_dmem_we), .io_dmem_ack(io_dmem_ack),
    .io_br_taken(io_br_taken), .io_ir_we(io_ir_we), .io_opb_sel(io_opb_sel),
    .io_alu_fun(io_alu_fun), .io_rf_we(io_rf_we), .io_wb_sel(io_wb_sel),
    .io_pc_we(io_pc_we), .io_pc_sel(io_pc_sel), .io_illegal(io_illegal)
  );

  assign act = {io_imem_req, io_ir_we, io_dmem_req, io_dmem_we, io_opb_sel, io_alu_fun,
                io_rf_we, io_wb_sel, io_pc_we, io_pc_sel, io_illegal};

  function automatic outs_t o(input logic imr, irw, dr, dwe, input logic [1:0] opb,
                              input logic [3:0] fun, input logic rfw, wbs, pcw, pcs, ill);
    o = {imr, irw, dr, dwe, opb, fun, rfw, wbs, pcw, pcs, ill};
  endfunction

  function automatic vec_t v(input logic r, ia, da, br, input outs_t e);
    v = {r, ia, da, br, e};
  endfunction

  // Reference ALU function straight from the instruction-set tables.
  function automatic logic [3:0] ref_fun(input logic [31:0] i);
    logic is_op;
    is_op = (i[6:0] == 7'b0110011);
    case (i[6:0])
      7'b0000011, 7'b0100011: ref_fun = 4'd0;
      7'b1100011:             ref_fun = 4'd1;
      default: begin
        case (i[14:12])
          3'd0: ref_fun = (is_op && i[30]) ? 4'd1 : 4'd0;
          3'd1: ref_fun = 4'd2;
          3'd2: ref_fun = 4'd3;
          3'd3: ref_fun = 4'd4;
          3'd4: ref_fun = 4'd5;
          3'd5: ref_fun = i[30] ? 4'd7 : 4'd6;
          3'd6: ref_fun = 4'd8;
          default: ref_fun = 4'd9;
        endcase
      end
    endcase
  endfunction

  function automatic logic rb();
    rb = 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle trace of one instruction given fetch/memory wait counts.
  task automatic model(input logic [31:0] inst, input int fw, input int mw, input logic br);
    logic is_load, is_store, is_br;
    logic [1:0] opb;
    logic [3:0] fun;
    is_load  = (inst[6:0] == 7'b0000011);
    is_store = (inst[6:0] == 7'b0100011);
    is_br    = (inst[6:0] == 7'b1100011);
    opb = is_store ? 2'd3 : ((is_load || inst[6:0] == 7'b0010011) ? 2'd2 : 2'd0);
    fun = ref_fun(inst);
    for (int k = 0; k < fw; k++) q.push_back(v(0, 0, rb(), rb(), o(1,0,0,0,0,0,0,0,0,0,0)));
    q.push_back(v(0, 1, rb(), rb(), o(1,1,0,0,0,0,0,0,0,0,0)));
    q.push_back(v(0, rb(), rb(), rb(), o(0,0,0,0,0,0,0,0,0,0,0)));
    if (is_br) begin
      q.push_back(v(0, rb(), rb(), br, o(0,0,0,0,opb,fun,0,0,1,br,0)));
      return;
    end
    q.push_back(v(0, rb(), rb(), rb(), o(0,0,0,0,opb,fun,0,0,0,0,0)));
    if (is_load || is_store) begin
      for (int k = 0; k <= mw; k++)
        q.push_back(v(0, rb(), k == mw, rb(),
                      o(0,0,1,is_store,opb,fun,0,0,is_store && k == mw,0,0)));
      if (is_store) return;
    end
    q.push_back(v(0, rb(), rb(), rb(), o(0,0,0,0,0,0,1,is_load,1,0,0)));
  endtask

  task automatic run(input string name);
    vec_t e;
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      reset       = e.rst;
      io_imem_ack = e.imem_ack;
      io_dmem_ack = e.dmem_ack;
      io_br_taken = e.br;
      @(negedge clk);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s[%0d]: got %b expected %b (req,irwe,dreq,dwe,opb,fun,rfwe,wbsel,pcwe,pcsel,ill)",
                 name, i, act, e.exp);
      end
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam outs_t Z  = '0;
  localparam outs_t FR = 15'b100000000000000;

  initial begin
    reset = 1'b1; io_inst = 32'h0; io_imem_ack = 1'b0; io_dmem_ack = 1'b0; io_br_taken = 1'b0;
    @(posedge clk); #1;

    // Reset gating, then idle instruction memory.
    q.push_back(v(1, 0, 0, 0, Z));
    q.push_back(v(1, 1, 1, 0, Z));
    for (int k = 0; k < 5; k++) q.push_back(v(0, 0, 0, 0, FR));
    run("reset_idle");

    io_inst = 32'h002081B3;  // ADD x3,x1,x2
    q.push_back(v(0, 1, 0, 0, o(1,1,0,0,0,0,0,0,0,0,0)));
    q.push_back(v(0, 0, 0, 0, Z));
    q.push_back(v(0, 0, 1, 0, o(0,0,0,0,0,0,0,0,0,0,0)));
    q.push_back(v(0, 0, 0, 0, o(0,0,0,0,0,0,1,0,1,0,0)));
    q.push_back(v(0, 0, 0, 0, FR));
    run("add");

    io_inst = 32'h0000A183;  // LW, two data wait cycles
    q.push_back(v(0, 1, 0, 0, o(1,1,0,0,0,0,0,0,0,0,0)));
    q.push_back(v(0, 0, 0, 0, Z));
    q.push_back(v(0, 0, 0, 0, o(0,0,0,0,2,0,0,0,0,0,0)));
    q.push_back(v(0, 0, 0, 0, o(0,0,1,0,2,0,0,0,0,0,0)));
    q.push_back(v(0, 0, 0, 0, o(0,0,1,0,2,0,0,0,0,0,0)));
    q.push_back(v(0, 0, 1, 0, o(0,0,1,0,2,0,0,0,0,0,0)));
    q.push_back(v(0, 0, 0, 0, o(0,0,0,0,0,0,1,1,1,0,0)));
    run("lw");

    io_inst = 32'h0020A223;  // SW
    q.push_back(v(0, 1, 0, 0, o(1,1,0,0,0,0,0,0,0,0,0)));
    q.push_back(v(0, 0, 0, 0, Z));
    q.push_back(v(0, 0, 0, 0, o(0,0,0,0,3,0,0,0,0,0,0)));
    q.push_back(v(0, 0, 1, 0, o(0,0,1,1,3,0,0,0,1,0,0)));
    q.push_back(v(0, 0, 0, 0, FR));
    run("sw");

    io_inst = 32'h00208463;  // BEQ taken, then not taken
    for (int t = 1; t >= 0; t--) begin
      q.push_back(v(0, 1, 0, 0, o(1,1,0,0,0,0,0,0,0,0,0)));
      q.push_back(v(0, 0, 0, 0, Z));
      q.push_back(v(0, 0, 0, 1'(t), o(0,0,0,0,0,1,0,0,1,1'(t),0)));
      run(t ? "beq_taken" : "beq_not_taken");
    end

    io_inst = 32'h0000A183;  // reset with a data request outstanding
    q.push_back(v(0, 1, 0, 0, o(1,1,0,0,0,0,0,0,0,0,0)));
    q.push_back(v(0, 0, 0, 0, Z));
    q.push_back(v(0, 0, 0, 0, o(0,0,0,0,2,0,0,0,0,0,0)));
    q.push_back(v(0, 0, 0, 0, o(0,0,1,0,2,0,0,0,0,0,0)));
    q.push_back(v(1, 0, 1, 0, Z));
    q.push_back(v(0, 0, 0, 0, FR));
    run("reset_mid_mem");

    io_inst = 32'h0000007F;  // illegal opcode, sticky until reset
    q.push_back(v(0, 1, 0, 0, o(1,1,0,0,0,0,0,0,0,0,0)));
    q.push_back(v(0, 0, 0, 0, Z));
    for (int k = 0; k < 10; k++) q.push_back(v(0, 1'(k % 2), 1'(k % 3 == 0), 0, o(0,0,0,0,0,0,0,0,0,0,1)));
    q.push_back(v(1, 0, 0, 0, Z));
    q.push_back(v(0, 0, 0, 0, FR));
    run("trap");

    for (int n = 0; n < 60; n++) begin
      logic [31:0] inst;
      logic [6:0]  opcs [5];
      opcs[0] = 7'b0110011; opcs[1] = 7'b0010011; opcs[2] = 7'b0000011;
      opcs[3] = 7'b0100011; opcs[4] = 7'b1100011;
      inst = $urandom;
      inst[6:0] = opcs[$urandom_range(0, 4)];
      io_inst = inst;
      model(inst, $urandom_range(0, 3), $urandom_range(0, 3), rb());
      run("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RV32I core datapath. Walks each instruction through FETCH, DECODE, EXEC, MEM and WB. Drives operand-B mux select, ALU function, register-file/PC/IR write enables and the instruction/data memory request handshakes. Sits beside the datapath, consumes the latched instruction word and branch outcome, and owns all sequencing; the datapath holds no control state.

## Interface
- No parameters; widths fixed at RV32.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- io_inst  in  32  instruction register contents (valid from DECODE onward).
- io_imem_req  out  1  instruction fetch request.
- io_imem_ack  in  1  fetch complete; instruction data valid this cycle.
- io_dmem_req  out  1  data memory request.
- io_dmem_we  out  1  data request is a store.
- io_dmem_ack  in  1  data access complete.
- io_br_taken  in  1  branch condition from comparator, valid in EXEC.
- io_ir_we  out  1  latch instruction register.
- io_opb_sel  out  2  operand B select: 0 = rsb, 1 = pc, 2 = imm-I, 3 = imm-S.
- io_alu_fun  out  4  ALU function code (package encoding).
- io_rf_we  out  1  register-file write enable.
- io_wb_sel  out  1  writeback source: 0 = ALU, 1 = load data.
- io_pc_we  out  1  PC write enable.
- io_pc_sel  out  1  PC source: 0 = pc+4, 1 = branch target.
- io_illegal  out  1  sticky illegal-instruction flag.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP; reset state FETCH.
- FETCH
  - io_imem_req=1 every cycle until io_imem_ack.
  - On the ack cycle: io_ir_we=1, next state DECODE.
- DECODE: classify io_inst[6:0].
  - Legal classes: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - Any other opcode → TRAP.
- EXEC: io_opb_sel and io_alu_fun valid.
  - OP: opb=0, fun from funct3 plus funct7[5].
  - OP-IMM: opb=2, fun from funct3; funct7[5] is honoured only for funct3=101 (SRAI).
  - LOAD: opb=2, fun=ADD.
  - STORE: opb=3, fun=ADD.
  - BRANCH: opb=0, fun=SUB; io_pc_we=1, io_pc_sel=io_br_taken, next state FETCH.
  - OP and OP-IMM → WB; LOAD and STORE → MEM.
- MEM
  - io_dmem_req=1 until io_dmem_ack; io_dmem_we=1 for STORE.
  - opb/fun are held at their EXEC values.
  - On ack: STORE → FETCH with io_pc_we=1, pc_sel=0; LOAD → WB.
- WB: io_rf_we=1, io_wb_sel=1 for LOAD, io_pc_we=1, pc_sel=0; next state FETCH.
- rd=x0 is not special-cased here; the register file ignores writes to x0.
- TRAP
  - io_illegal=1; all enables and requests are 0.
  - The only exit is reset.
- Default output values in any state where an output is not named: 0. This includes io_opb_sel=0 and io_alu_fun=ADD.

## Timing
- All outputs are combinational from the state register and io_inst; no output registers.
- Reset
  - While reset is high, the state is forced to FETCH at each edge.
  - Outputs are gated to 0 during reset.
  - The first io_imem_req appears in the first cycle after reset deasserts.
- Reset mid-operation, including an outstanding memory request: the request drops the same cycle reset is sampled. The memory must tolerate an abandoned request.
- Handshakes
  - Requests stay high until their ack.
  - An ack while the matching req is low is ignored.
  - Ack in the first request cycle gives zero wait.
- Cycle counts with zero-wait memory:
  - OP / OP-IMM: 4 (F, D, E, W).
  - LOAD: 5.
  - STORE: 4.
  - BRANCH: 3.
- Each extra wait cycle adds one.
- io_pc_we pulses exactly once per retired instruction; io_ir_we exactly once per fetch.

## Structure
- Shared package `core_ctrl_pkg`:
  - state enum.
  - opcode constants.
  - ALU codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - OPB_RSB=0, OPB_PC=1, OPB_IMI=2, OPB_IMS=3.
- One natural sub-module: `alu_fun_decode`, mapping (opcode class, funct3, funct7[5]) to io_alu_fun.
- The FSM stays in the top level.

## Test plan
- Reset, then idle memory (imem_ack=0 for 5 cycles) → imem_req=1 for all 5 cycles, no other enables, illegal=0.
- ADD x3,x1,x2 (0x002081B3), zero-wait → F ir_we, D, E opb=0 fun=0, W rf_we=1 pc_we=1; 4 cycles total.
- LW (0x0000A183) with dmem_ack after 2 wait cycles → E opb=2 fun=0, MEM req for 3 cycles with we=0, W wb_sel=1; 7 cycles total.
- SW (0x0020A223) → E opb=3, MEM dmem_we=1, pc_we on ack, no rf_we.
- BEQ with io_br_taken=1, then again with 0 → E fun=1 opb=0, pc_we=1 with pc_sel=1 then 0; 3 cycles each.
- Opcode 0x7F, then reset asserted in the TRAP state → illegal=1 and held for 10 cycles; after reset, illegal=0 and imem_req=1.
